// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings for the I2C command sequencer.
//   - response status codes carried on rsp_status
//   - sequencer FSM state type
//   - chip address width and a saturating counter helper
package i2c_pkg;

  localparam int I2C_CHIP_ADDR_W = 7;

  localparam logic [1:0] I2C_RSP_OK      = 2'd0;
  localparam logic [1:0] I2C_RSP_NACK    = 2'd1;
  localparam logic [1:0] I2C_RSP_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_RESP      = 3'd5
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock FIFO with a registered head output.
//   clk, reset (sync, active-low)
//   push/wdata : write side, ignored when full unless a pop happens the same cycle
//   pop        : removes the head, ignored when empty
//   rdata      : current head, valid the cycle after it is pushed
//   full/empty : occupancy flags
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata_d  = rdata_q;
    // The slot being written this cycle may become the new head
    // (empty FIFO, or popping the last entry), so bypass the array.
    if (cnt_d != '0)
      rdata_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues read/write commands and drives i2c_master one
// transfer at a time, with NACK retry, backoff and per-attempt timeout.
//   clk, reset (sync, active-low)
//   cmd_*  : command push handshake {rw, chip, reg, data}
//   rsp_*  : one response per command {rw, data, status, retries}
//   m_*    : i2c_master request outputs / status inputs
//   err_count : saturating count of non-OK responses
//   idle      : nothing queued and no transfer in flight
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int MAX_RETRIES    = 2,
  parameter int BACKOFF_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int RA_W = 8*ADDR_BYTES,
  localparam int D_W  = 8*DATA_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_rw,
  input  logic [I2C_CHIP_ADDR_W-1:0] cmd_chip_addr,
  input  logic [RA_W-1:0]            cmd_reg_addr,
  input  logic [D_W-1:0]             cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_rw,
  output logic [D_W-1:0]             rsp_data,
  output logic [1:0]                 rsp_status,
  output logic [3:0]                 rsp_retries,
  output logic [I2C_CHIP_ADDR_W-1:0] m_chip_addr,
  output logic [RA_W-1:0]            m_reg_addr,
  output logic [D_W-1:0]             m_data_in,
  output logic                       m_write_en,
  output logic                       m_read_en,
  output logic                       m_write_mode,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic [3:0]                 m_status,
  input  logic [D_W-1:0]             m_data_out,
  output logic [7:0]                 err_count,
  output logic                       idle
);

  localparam int CMD_W = 1 + I2C_CHIP_ADDR_W + RA_W + D_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BO_W-1:0]  BO_LAST  = BO_W'(BACKOFF_CYCLES - 1);

  // Command FIFO
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic                       f_rw;
  logic [I2C_CHIP_ADDR_W-1:0] f_chip;
  logic [RA_W-1:0]            f_reg;
  logic [D_W-1:0]             f_data;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {f_rw, f_chip, f_reg, f_data} = fifo_rdata;

  i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State
  seq_state_e                 state_q, state_d;
  logic                       act_rw_q, act_rw_d;
  logic [I2C_CHIP_ADDR_W-1:0] act_chip_q, act_chip_d;
  logic [RA_W-1:0]            act_reg_q, act_reg_d;
  logic [D_W-1:0]             act_data_q, act_data_d;
  logic [3:0]                 retries_q, retries_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [BO_W-1:0]            bo_q, bo_d;
  logic                       rsp_rw_q, rsp_rw_d;
  logic [D_W-1:0]             rsp_data_q, rsp_data_d;
  logic [1:0]                 rsp_status_q, rsp_status_d;
  logic [3:0]                 rsp_retries_q, rsp_retries_d;
  logic [7:0]                 err_q, err_d;
  logic                       finish;
  logic [1:0]                 fin_status;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  always_comb begin
    state_d       = state_q;
    act_rw_d      = act_rw_q;
    act_chip_d    = act_chip_q;
    act_reg_d     = act_reg_q;
    act_data_d    = act_data_q;
    retries_d     = retries_q;
    tmo_d         = tmo_q;
    bo_d          = bo_q;
    rsp_rw_d      = rsp_rw_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_retries_d = rsp_retries_q;
    err_d         = err_q;
    finish        = 1'b0;
    fin_status    = I2C_RSP_OK;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          {act_rw_d, act_chip_d, act_reg_d, act_data_d} = fifo_rdata;
          retries_d = '0;
          tmo_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        // m_done takes priority over a timeout expiring in the same cycle,
        // and is honoured even if busy was never observed.
        if (m_done) begin
          if (m_status == 4'h0) begin
            finish = 1'b1;
          end else if (retries_q < MAX_R) begin
            retries_d = retries_q + 4'd1;
            bo_d      = '0;
            state_d   = ST_BACKOFF;
          end else begin
            finish     = 1'b1;
            fin_status = I2C_RSP_NACK;
          end
        end else if (tmo_q == TMO_LAST) begin
          finish     = 1'b1;
          fin_status = I2C_RSP_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (state_q == ST_WAIT_BUSY && m_busy) state_d = ST_WAIT_DONE;
        end
      end
      ST_BACKOFF: begin
        if (bo_q == BO_LAST) state_d = ST_ISSUE;
        else                 bo_d    = bo_q + BO_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      rsp_rw_d      = act_rw_q;
      rsp_status_d  = fin_status;
      rsp_retries_d = retries_q;
      rsp_data_d    = (fin_status == I2C_RSP_OK && act_rw_q) ? m_data_out : '0;
      if (fin_status != I2C_RSP_OK) err_d = sat_inc8(err_q);
      state_d = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      act_rw_q      <= 1'b0;
      act_chip_q    <= '0;
      act_reg_q     <= '0;
      act_data_q    <= '0;
      retries_q     <= '0;
      tmo_q         <= '0;
      bo_q          <= '0;
      rsp_rw_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      rsp_retries_q <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      act_rw_q      <= act_rw_d;
      act_chip_q    <= act_chip_d;
      act_reg_q     <= act_reg_d;
      act_data_q    <= act_data_d;
      retries_q     <= retries_d;
      tmo_q         <= tmo_d;
      bo_q          <= bo_d;
      rsp_rw_q      <= rsp_rw_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_retries_q <= rsp_retries_d;
      err_q         <= err_d;
    end
  end

  // Outputs
  assign m_chip_addr  = act_chip_q;
  assign m_reg_addr   = act_reg_q;
  assign m_data_in    = act_data_q;
  assign m_write_en   = (state_q == ST_ISSUE) && !act_rw_q;
  assign m_read_en    = (state_q == ST_ISSUE) &&  act_rw_q;
  assign m_write_mode = 1'b0;

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rw      = rsp_rw_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_retries = rsp_retries_q;
  assign err_count   = err_q;
  assign idle        = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;

  localparam int MAXR = 2;
  localparam int BO   = 64;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0]  cmd_chip_addr = '0;
  logic [7:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_rw;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_retries;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr;
  logic [15:0] m_data_in, m_data_out;
  logic        m_write_en, m_read_en, m_write_mode;
  logic        m_busy, m_done;
  logic [3:0]  m_status;
  logic [7:0]  err_count;
  logic        idle;

  i2c_cmd_sequencer #(
    .ADDR_BYTES(1), .DATA_BYTES(2), .FIFO_DEPTH(8),
    .MAX_RETRIES(MAXR), .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_chip_addr(cmd_chip_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en), .m_write_mode(m_write_mode),
    .m_busy(m_busy), .m_done(m_done), .m_status(m_status), .m_data_out(m_data_out),
    .err_count(err_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Read data the master model returns for a register.
  function automatic logic [15:0] f_rd(input logic [7:0] r);
    return {r ^ 8'hD3, r ^ 8'hD3};
  endfunction

  // ---------------- master model ----------------
  bit          hold = 1'b0;     // keep busy high, withhold done
  bit          no_busy = 1'b0;  // ignore enables entirely
  int          nack_left = 0;   // NACK this many completions first
  int          stab_err = 0;
  int          mcnt = 0;
  logic [31:0] lat = '0;        // {rw, chip, reg, data} seen at the pulse
  logic [31:0] pulse_q[$];
  int          pulse_cyc[$];
  int          done_cyc[$];

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_status <= '0; m_data_out <= '0;
      mcnt = 0;
    end else begin
      m_done <= 1'b0;
      if (mcnt != 0) begin
        if (m_chip_addr !== lat[30:24] || m_reg_addr !== lat[23:16] || m_data_in !== lat[15:0])
          stab_err = stab_err + 1;
        if (mcnt == 3 && !hold) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          done_cyc.push_back(cyc + 1);
          if (nack_left > 0) begin m_status <= 4'h1; nack_left = nack_left - 1; end
          else m_status <= 4'h0;
          m_data_out <= f_rd(lat[23:16]);
          mcnt = 0;
        end else if (mcnt < 3) mcnt = mcnt + 1;
      end
      if (m_write_en || m_read_en) begin
        pulse_q.push_back({m_read_en, m_chip_addr, m_reg_addr, m_data_in});
        pulse_cyc.push_back(cyc);
        lat = {m_read_en, m_chip_addr, m_reg_addr, m_data_in};
        if (!no_busy) begin mcnt = 1; m_busy <= 1'b1; end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [6:0] ch, input logic [7:0] ra,
                      input logic [15:0] d, output int acc);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_chip_addr = ch; cmd_reg_addr = ra; cmd_data = d;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("push_accept", 0, 1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) begin vcyc = cyc; return; end
      @(negedge clk);
    end
    chk("rsp_arrival", 0, 1);
  endtask

  task automatic take_rsp(output logic rw, output logic [15:0] d,
                          output logic [1:0] st, output logic [3:0] rt);
    rw = rsp_rw; d = rsp_data; st = rsp_status; rt = rsp_retries;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, vc, pb, db, n, exp_err;
    logic rw;
    logic [15:0] d;
    logic [1:0] st;
    logic [3:0] rt;
    logic [31:0] exp_cmds[$];
    logic [31:0] c;

    exp_err = 0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_en", {m_write_en, m_read_en, m_write_mode}, 0);
    chk("rst_m_addr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
    chk("rst_rsp_fields", {rsp_rw, rsp_data, rsp_status, rsp_retries}, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: write chip 0x0F reg 0x0A data 0xB2B2
    pb = pulse_q.size(); db = done_cyc.size();
    push(1'b0, 7'h0F, 8'h0A, 16'hB2B2, acc);
    wait_valid(vc);
    chk("w_pulses", pulse_q.size() - pb, 1);
    if (pulse_q.size() > pb) begin
      chk("w_pulse_fields", pulse_q[pb], {1'b0, 7'h0F, 8'h0A, 16'hB2B2});
      chk("w_pulse_latency", pulse_cyc[pb] - acc, 2);
    end
    if (done_cyc.size() > db) chk("w_done_to_rsp", vc - done_cyc[db], 1);
    repeat (3) @(negedge clk);   // hold off rsp_ready: everything must stay put
    chk("w_rsp_hold_valid", rsp_valid, 1);
    chk("w_m_hold", {m_chip_addr, m_reg_addr, m_data_in}, {7'h0F, 8'h0A, 16'hB2B2});
    take_rsp(rw, d, st, rt);
    chk("w_rsp", {rw, d, st, rt}, {1'b0, 16'h0, 2'd0, 4'd0});
    chk("w_stab", stab_err, 0);

    // 2: read chip 0x0F reg 0x10
    pb = pulse_q.size();
    push(1'b1, 7'h0F, 8'h10, 16'h0000, acc);
    wait_valid(vc);
    take_rsp(rw, d, st, rt);
    chk("r_pulses", pulse_q.size() - pb, 1);
    if (pulse_q.size() > pb) chk("r_pulse_rw", pulse_q[pb][31], 1);
    chk("r_rsp", {rw, d, st, rt}, {1'b1, 16'hC3C3, 2'd0, 4'd0});

    // 3a: NACK twice then OK
    pb = pulse_q.size(); db = done_cyc.size();
    nack_left = 2;
    push(1'b0, 7'h22, 8'h33, 16'($urandom), acc);
    wait_valid(vc);
    take_rsp(rw, d, st, rt);
    chk("retry_pulses", pulse_q.size() - pb, 3);
    for (int k = 0; k < 2; k++)
      if (pulse_cyc.size() > pb + k + 1 && done_cyc.size() > db + k)
        chk("retry_backoff_gap",
            (pulse_cyc[pb+k+1] - done_cyc[db+k] >= BO + 1) &&
            (pulse_cyc[pb+k+1] - done_cyc[db+k] <= BO + 2), 1);
    chk("retry_rsp", {rw, st, rt}, {1'b0, 2'd0, 4'd2});
    chk("retry_err", err_count, exp_err);

    // 3b: three NACKs exhaust retries
    pb = pulse_q.size();
    nack_left = 3;
    push(1'b1, 7'h22, 8'h34, 16'h0, acc);
    wait_valid(vc);
    take_rsp(rw, d, st, rt);
    exp_err++;
    chk("nack_pulses", pulse_q.size() - pb, 3);
    chk("nack_rsp", {rw, d, st, rt}, {1'b1, 16'h0, 2'd1, 4'd2});
    chk("nack_err", err_count, exp_err);

    // 4: master never goes busy -> timeout, no retry
    pb = pulse_q.size();
    no_busy = 1'b1;
    push(1'b1, 7'h45, 8'h12, 16'h0, acc);
    wait_valid(vc);
    take_rsp(rw, d, st, rt);
    no_busy = 1'b0;
    exp_err++;
    chk("tmo_pulses", pulse_q.size() - pb, 1);
    if (pulse_cyc.size() > pb) chk("tmo_latency", vc - pulse_cyc[pb], TMO + 1);
    chk("tmo_rsp", {rw, d, st, rt}, {1'b1, 16'h0, 2'd2, 4'd0});
    chk("tmo_err", err_count, exp_err);

    // 5: stall master, 9 random commands at depth 8
    pb = pulse_q.size();
    hold = 1'b1;
    exp_cmds.delete();
    for (int k = 0; k < 9; k++) begin
      c = $urandom;
      exp_cmds.push_back(c);
      push(c[31], c[30:24], c[23:16], c[15:0], acc);
    end
    chk("fifo_full_ready", cmd_ready, 0);
    chk("fifo_full_idle", idle, 0);
    hold = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_valid(vc);
      if (vc < 0) break;
      take_rsp(rw, d, st, rt);
      c = exp_cmds[k];
      chk("fifo_rsp", {rw, d, st, rt}, {c[31], c[31] ? f_rd(c[23:16]) : 16'h0, 2'd0, 4'd0});
    end
    chk("fifo_pulses", pulse_q.size() - pb, 9);
    for (int k = 0; k < 9; k++)
      if (pulse_q.size() > pb + k) chk("fifo_order", pulse_q[pb+k], exp_cmds[k]);
    chk("fifo_stab", stab_err, 0);
    chk("fifo_drained_idle", idle, 1);

    // 6: reset while waiting for done
    hold = 1'b1;
    push(1'b0, 7'h51, 8'h77, 16'hBEEF, acc);
    for (int i = 0; i < 20 && !m_busy; i++) @(negedge clk);
    chk("rst_mid_busy", m_busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold = 1'b0;
    exp_err = 0;
    chk("rst_mid_en", {m_write_en, m_read_en, m_write_mode}, 0);
    chk("rst_mid_addr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
    chk("rst_mid_rsp", {rsp_valid, rsp_rw, rsp_data, rsp_status, rsp_retries}, 0);
    chk("rst_mid_err", err_count, 0);
    chk("rst_mid_flags", {cmd_ready, idle}, 2'b11);
    pb = pulse_q.size();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_mid_no_rsp", n, 0);
    chk("rst_mid_no_pulse", pulse_q.size() - pb, 0);

    // 7: random commands against reference rules
    for (int k = 0; k < 4; k++) begin
      c = $urandom;
      n = $urandom_range(0, 3);
      pb = pulse_q.size();
      nack_left = n;
      push(c[31], c[30:24], c[23:16], c[15:0], acc);
      wait_valid(vc);
      take_rsp(rw, d, st, rt);
      if (n > MAXR) exp_err++;
      chk("rnd_pulses", pulse_q.size() - pb, (n > MAXR ? MAXR : n) + 1);
      chk("rnd_rsp", {rw, d, st, rt},
          {c[31], (c[31] && n <= MAXR) ? f_rd(c[23:16]) : 16'h0,
           (n > MAXR) ? 2'd1 : 2'd0, 4'((n > MAXR) ? MAXR : n)});
      chk("rnd_err", err_count, exp_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
